predictor_sched: RTL and testbench
==================================

Name: predictor_sched

Overview:
- Sample-period scheduler and sequencer for the MPC output-predictor core (ap_ctrl_hs block: 2-entry xhat memory ports, uk, yhat with ap_vld).
- Generates the control-period tick and snapshots xhat[0..1] and uk from the observer.
- Serves the snapshot to the predictor's two 1-cycle-latency xhat read ports, runs one predictor transaction per tick and captures yhat.
- Flags period overruns and hung transactions; sits between the observer/plant interface and the predictor.

Parameters:
- PERIOD_CYCLES, 1000: enabled (ce_1=1) cycles per control period; legal range ≥ 2.
- TIMEOUT_CYCLES, 64: maximum cycles in RUN before abort; legal range ≥ 1.
- DATA_W, 64: Q32.32 signed data width.

Ports:
- clk_1  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- ce_1  in  1  period-counter clock enable
- period_en  in  1  enable periodic scheduling
- err_clr  in  1  clear sticky error flags
- xhat0_in, xhat1_in  in  DATA_W  observer state estimate
- uk_in  in  DATA_W  applied plant input
- pred_ap_start  out  1  predictor start
- pred_ap_done, pred_ap_ready, pred_ap_idle  in  1  predictor handshake
- pred_xhat_address0, pred_xhat_address1  in  1  predictor read addresses
- pred_xhat_ce0, pred_xhat_ce1  in  1  predictor read enables
- pred_xhat_q0, pred_xhat_q1  out  DATA_W  read data
- pred_uk  out  DATA_W  snapshot uk
- pred_yhat  in  DATA_W  predictor output
- pred_yhat_ap_vld  in  1  yhat valid
- yhat_out  out  DATA_W  last captured prediction
- yhat_valid  out  1  1-cycle pulse on new yhat_out
- busy  out  1  state != IDLE
- overrun  out  1  sticky: tick arrived while busy
- timeout_err  out  1  sticky: RUN exceeded TIMEOUT_CYCLES

Behaviour:
- Reset (ap_rst_n=0, async): state IDLE; period counter, snapshot registers, q0/q1, yhat_out and timeout counter cleared to 0; pred_ap_start, yhat_valid, busy, overrun and timeout_err all 0. A reset mid-transaction drops pred_ap_start immediately. The predictor's own reset is not driven by this block.
- Period counter: counts 0..PERIOD_CYCLES-1 only when ce_1=1 and wraps to 0.
  - tick = ce_1 & (count == PERIOD_CYCLES-1).
  - Counter runs regardless of period_en and state.
- FSM states: IDLE, RUN, DONE.
- IDLE: on tick & period_en, latch xhat0_in, xhat1_in and uk_in into the snapshot registers and go to RUN. A tick with period_en=0 is ignored.
- RUN:
  - pred_ap_start=1, held high until handshake completes.
  - Timeout counter increments each cycle.
  - If pred_yhat_ap_vld=1, capture pred_yhat into a holding register.
  - On pred_ap_done=1: deassert start next cycle and go to DONE. ready and done coincide on this core, so done terminates the handshake.
  - If the timeout counter reaches TIMEOUT_CYCLES before done: set timeout_err, drop start, return to IDLE, no yhat_valid, yhat_out unchanged.
- DONE: yhat_out <= captured value; yhat_valid=1 for exactly this cycle; go to IDLE. Timeout counter cleared.
- Latency: tick at cycle T → start high at T+1; done at cycle D → yhat_valid and new yhat_out at D+1.
- Read ports: pred_xhat_qN <= snapshot[pred_xhat_addressN] on cycles with pred_xhat_ceN=1 (1-cycle latency); q holds when ce=0. Both ports are independent and may read the same address.
- pred_uk is driven combinationally from the uk snapshot; it is stable for the whole RUN.
- Snapshot registers change only on the IDLE→RUN transition.
- Overrun: a tick while state != IDLE sets overrun and the tick is dropped; no queuing.
- err_clr clears overrun and timeout_err. If a set and a clear occur in the same cycle, set wins.
- busy = (state != IDLE).
- No arithmetic on yhat: saturation to ±8.0 is done inside the predictor; this block passes the value bit-exact.

Decomposition:
- Shared package (mpc_pkg): DATA_W, Q32.32 fraction width (32), state enum {IDLE, RUN, DONE}, default PERIOD/TIMEOUT constants.
- One natural sub-module: mpc_period_tick (counter plus tick generation with ce_1), reusable by the other MPC controllers.
- The FSM, snapshot and read ports stay in predictor_sched.

Test Plan:
- PERIOD=10, ce_1=1, period_en=1, predictor model with done 12 cycles after start returning yhat=0x0000_0001_8000_0000 → start rises at T+1; yhat_valid pulses once at D+1; yhat_out=0x0000_0001_8000_0000; busy low after.
- Tick with xhat0=0x5, xhat1=0x7, uk=0x9; predictor reads addr1 then addr0 via both ports → q1=0x7 and q0=0x5 one cycle after ce; pred_uk=0x9. Inputs change during RUN → q and pred_uk unchanged.
- PERIOD=10, predictor done after 15 cycles → overrun=1 at the second tick; only one yhat_valid per transaction; err_clr pulse → overrun=0.
- TIMEOUT=64, predictor never asserts done → timeout_err=1 after 64 RUN cycles; start=0; state IDLE; yhat_out keeps its previous value; the next tick starts a new transaction.
- ce_1 toggling 1/0 each cycle with PERIOD=10 → ticks every 20 clk_1 cycles. period_en=0 → no start, no overrun.
- ap_rst_n asserted low mid-RUN (asynchronously, between edges) → start, busy and yhat_valid go 0 immediately; all outputs 0; after release the first transaction follows the first tick.

Source files
------------

// File: rtl/mpc_pkg.sv
// Shared types and defaults for the MPC controller blocks (Q32.32 data path).
// Pure declarations; no latency, no flow control.
package mpc_pkg;

    localparam int DEF_DATA_W         = 64;
    localparam int FRAC_W             = 32;
    localparam int DEF_PERIOD_CYCLES  = 1000;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mpc_period_tick.sv
// Control-period counter: counts enabled cycles 0..PERIOD_CYCLES-1 and flags the last one.
// tick is combinational in the final enabled cycle; no backpressure, counter free-runs.
module mpc_period_tick
    import mpc_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    output logic tick
);

    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = ce && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ce) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/predictor_sched.sv
// Runs one predictor (ap_ctrl_hs) transaction per control tick on a snapshot of xhat/uk.
// Start at tick+1, yhat_valid at done+1; ticks while busy are dropped and flagged as overrun.
module predictor_sched
    import mpc_pkg::*;
#(
    parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int DATA_W         = DEF_DATA_W
) (
    input  logic              clk_1,
    input  logic              ap_rst_n,
    input  logic              ce_1,
    input  logic              period_en,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] xhat0_in,
    input  logic [DATA_W-1:0] xhat1_in,
    input  logic [DATA_W-1:0] uk_in,
    output logic              pred_ap_start,
    input  logic              pred_ap_done,
    input  logic              pred_ap_ready,
    input  logic              pred_ap_idle,
    input  logic              pred_xhat_address0,
    input  logic              pred_xhat_address1,
    input  logic              pred_xhat_ce0,
    input  logic              pred_xhat_ce1,
    output logic [DATA_W-1:0] pred_xhat_q0,
    output logic [DATA_W-1:0] pred_xhat_q1,
    output logic [DATA_W-1:0] pred_uk,
    input  logic [DATA_W-1:0] pred_yhat,
    input  logic              pred_yhat_ap_vld,
    output logic [DATA_W-1:0] yhat_out,
    output logic              yhat_valid,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic              tick;
    logic              launch;
    logic              run_done;
    logic              run_tmo;
    logic [TW-1:0]     tcnt;
    logic [DATA_W-1:0] snap_x0;
    logic [DATA_W-1:0] snap_x1;
    logic [DATA_W-1:0] snap_uk;
    logic [DATA_W-1:0] yhat_hold;

    // ready coincides with done on this core and idle carries no extra information.
    logic unused_hs;
    assign unused_hs = pred_ap_ready ^ pred_ap_idle;

    mpc_period_tick #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_period_tick (
        .clk  (clk_1),
        .rst_n(ap_rst_n),
        .ce   (ce_1),
        .tick (tick)
    );

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        run_done  = 1'b0;
        run_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (tick && period_en) begin
                    launch    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (pred_ap_done) begin
                    run_done  = 1'b1;
                    state_nxt = DONE;
                end else if (tcnt == T_LAST) begin
                    run_tmo   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            snap_x0 <= '0;
            snap_x1 <= '0;
            snap_uk <= '0;
        end else if (launch) begin
            snap_x0 <= xhat0_in;
            snap_x1 <= xhat1_in;
            snap_uk <= uk_in;
        end
    end

    // Counts RUN cycles; any exit from RUN leaves it at zero for the next transaction.
    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tcnt <= '0;
        end else if ((state == RUN) && !run_done && !run_tmo) begin
            tcnt <= tcnt + TW'(1);
        end else begin
            tcnt <= '0;
        end
    end

    // yhat_vld may coincide with done, so bypass the holding register to meet done+1.
    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            yhat_hold <= '0;
            yhat_out  <= '0;
        end else begin
            if ((state == RUN) && pred_yhat_ap_vld) begin
                yhat_hold <= pred_yhat;
            end
            if (run_done) begin
                yhat_out <= pred_yhat_ap_vld ? pred_yhat : yhat_hold;
            end
        end
    end

    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pred_xhat_q0 <= '0;
            pred_xhat_q1 <= '0;
        end else begin
            if (pred_xhat_ce0) begin
                pred_xhat_q0 <= pred_xhat_address0 ? snap_x1 : snap_x0;
            end
            if (pred_xhat_ce1) begin
                pred_xhat_q1 <= pred_xhat_address1 ? snap_x1 : snap_x0;
            end
        end
    end

    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (run_tmo) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign pred_ap_start = (state == RUN);
    assign busy          = (state != IDLE);
    assign yhat_valid    = (state == DONE);
    assign pred_uk       = snap_uk;

endmodule

// File: tb/tb_predictor_sched.sv
// Directed bench for predictor_sched with PERIOD=10, TIMEOUT=64; the predictor handshake is driven by hand.
module tb_predictor_sched;

    localparam int DW = 64;

    logic          clk_1 = 1'b0;
    logic          ap_rst_n;
    logic          ce_1;
    logic          period_en;
    logic          err_clr;
    logic [DW-1:0] xhat0_in;
    logic [DW-1:0] xhat1_in;
    logic [DW-1:0] uk_in;
    logic          pred_ap_start;
    logic          pred_ap_done;
    logic          pred_ap_ready;
    logic          pred_ap_idle;
    logic          pred_xhat_address0;
    logic          pred_xhat_address1;
    logic          pred_xhat_ce0;
    logic          pred_xhat_ce1;
    logic [DW-1:0] pred_xhat_q0;
    logic [DW-1:0] pred_xhat_q1;
    logic [DW-1:0] pred_uk;
    logic [DW-1:0] pred_yhat;
    logic          pred_yhat_ap_vld;
    logic [DW-1:0] yhat_out;
    logic          yhat_valid;
    logic          busy;
    logic          overrun;
    logic          timeout_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit ce_toggle = 1'b0;

    localparam logic [DW-1:0] Y1 = 64'h0000_0001_8000_0000;

    always #5 clk_1 = ~clk_1;

    predictor_sched #(
        .PERIOD_CYCLES (10),
        .TIMEOUT_CYCLES(64),
        .DATA_W        (DW)
    ) dut (
        .clk_1             (clk_1),
        .ap_rst_n          (ap_rst_n),
        .ce_1              (ce_1),
        .period_en         (period_en),
        .err_clr           (err_clr),
        .xhat0_in          (xhat0_in),
        .xhat1_in          (xhat1_in),
        .uk_in             (uk_in),
        .pred_ap_start     (pred_ap_start),
        .pred_ap_done      (pred_ap_done),
        .pred_ap_ready     (pred_ap_ready),
        .pred_ap_idle      (pred_ap_idle),
        .pred_xhat_address0(pred_xhat_address0),
        .pred_xhat_address1(pred_xhat_address1),
        .pred_xhat_ce0     (pred_xhat_ce0),
        .pred_xhat_ce1     (pred_xhat_ce1),
        .pred_xhat_q0      (pred_xhat_q0),
        .pred_xhat_q1      (pred_xhat_q1),
        .pred_uk           (pred_uk),
        .pred_yhat         (pred_yhat),
        .pred_yhat_ap_vld  (pred_yhat_ap_vld),
        .yhat_out          (yhat_out),
        .yhat_valid        (yhat_valid),
        .busy              (busy),
        .overrun           (overrun),
        .timeout_err       (timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // cyc counts rising edges since reset release; inputs change 1 time unit after each edge.
    task automatic step();
        @(posedge clk_1);
        #1;
        cyc++;
        if (ce_toggle) ce_1 = ~ce_1;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic pred_finish(input logic [DW-1:0] y);
        pred_ap_done     = 1'b1;
        pred_yhat_ap_vld = 1'b1;
        pred_yhat        = y;
    endtask

    task automatic pred_quiet();
        pred_ap_done     = 1'b0;
        pred_yhat_ap_vld = 1'b0;
        pred_yhat        = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    initial begin
        ap_rst_n = 1'b0; ce_1 = 1'b1; period_en = 1'b1; err_clr = 1'b0;
        xhat0_in = '0; xhat1_in = '0; uk_in = '0;
        pred_ap_done = 1'b0; pred_ap_ready = 1'b0; pred_ap_idle = 1'b1;
        pred_xhat_address0 = 1'b0; pred_xhat_address1 = 1'b0;
        pred_xhat_ce0 = 1'b0; pred_xhat_ce1 = 1'b0;
        pred_yhat = '0; pred_yhat_ap_vld = 1'b0;

        @(posedge clk_1); #1;
        chk("rst_start", pred_ap_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", yhat_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_yhat", yhat_out, 0);
        chk("rst_q0", pred_xhat_q0, 0);
        chk("rst_uk", pred_uk, 0);

        @(posedge clk_1); #1;
        ap_rst_n = 1'b1; cyc = 0;
        xhat0_in = 64'h5; xhat1_in = 64'h7; uk_in = 64'h9;

        // First tick is in cycle 9, so start appears after edge 10.
        step_to(9);  chk("pre_tick_start", pred_ap_start, 0);
        step_to(10); chk("t1_start", pred_ap_start, 1);
        chk("t1_busy", busy, 1);
        chk("t1_uk", pred_uk, 64'h9);

        xhat0_in = 64'hAA; xhat1_in = 64'hBB; uk_in = 64'hCC;
        pred_xhat_ce1 = 1'b1; pred_xhat_address1 = 1'b1;
        step();
        chk("rd_q1_addr1", pred_xhat_q1, 64'h7);
        chk("rd_q0_idle", pred_xhat_q0, 64'h0);
        pred_xhat_ce1 = 1'b0; pred_xhat_ce0 = 1'b1; pred_xhat_address0 = 1'b0;
        step();
        chk("rd_q0_addr0", pred_xhat_q0, 64'h5);
        chk("rd_q1_hold", pred_xhat_q1, 64'h7);
        pred_xhat_ce0 = 1'b1; pred_xhat_address0 = 1'b1;
        pred_xhat_ce1 = 1'b1; pred_xhat_address1 = 1'b1;
        step();
        chk("rd_same_q0", pred_xhat_q0, 64'h7);
        chk("rd_same_q1", pred_xhat_q1, 64'h7);
        pred_xhat_ce0 = 1'b0; pred_xhat_ce1 = 1'b0;
        pred_xhat_address0 = 1'b0; pred_xhat_address1 = 1'b0;
        step();
        chk("rd_q0_hold", pred_xhat_q0, 64'h7);
        chk("uk_stable", pred_uk, 64'h9);

        // Tick in cycle 19 lands while the 12-cycle transaction is still running.
        step_to(20);
        chk("t1_overrun", overrun, 1);
        chk("t1_still_busy", busy, 1);
        step_to(22);
        chk("t1_start_held", pred_ap_start, 1);
        pred_finish(Y1);
        step();
        chk("t1_valid", yhat_valid, 1);
        chk("t1_yhat", yhat_out, Y1);
        chk("t1_start_drop", pred_ap_start, 0);
        pred_quiet();
        step();
        chk("t1_valid_once", yhat_valid, 0);
        chk("t1_idle", busy, 0);
        chk("t1_yhat_keep", yhat_out, Y1);
        err_clr = 1'b1;
        step();
        chk("clr_overrun", overrun, 0);
        err_clr = 1'b0;

        // Second transaction: new snapshot, done 15 cycles after start.
        step_to(31); chk("t2_uk", pred_uk, 64'hCC);
        step_to(39); chk("t2_no_overrun", overrun, 0);
        step_to(40); chk("t2_overrun", overrun, 1);
        chk("t2_start", pred_ap_start, 1);
        step_to(45);
        pred_finish(64'h2);
        step();
        chk("t2_valid", yhat_valid, 1);
        chk("t2_yhat", yhat_out, 64'h2);
        pred_quiet();
        step();
        chk("t2_valid_once", yhat_valid, 0);
        chk("t2_idle", busy, 0);
        err_clr = 1'b1;
        step();
        chk("t2_clr", overrun, 0);
        err_clr = 1'b0;

        // Third transaction never completes: RUN cycles 50..113, abort after edge 114.
        step_to(50); chk("t3_start", pred_ap_start, 1);
        step_to(59);
        err_clr = 1'b1;
        step();
        chk("set_wins_clr", overrun, 1);
        err_clr = 1'b0;
        step_to(113);
        chk("t3_no_tmo_yet", timeout_err, 0);
        chk("t3_start_late", pred_ap_start, 1);
        step();
        chk("t3_timeout", timeout_err, 1);
        chk("t3_start_off", pred_ap_start, 0);
        chk("t3_idle", busy, 0);
        chk("t3_no_valid", yhat_valid, 0);
        chk("t3_yhat_keep", yhat_out, 64'h2);

        step_to(120); chk("t4_start", pred_ap_start, 1);
        pred_finish(64'h3);
        step();
        chk("t4_valid", yhat_valid, 1);
        chk("t4_yhat", yhat_out, 64'h3);
        pred_quiet();
        step();
        chk("t4_idle", busy, 0);
        err_clr = 1'b1;
        step();
        chk("clr_timeout", timeout_err, 0);
        chk("clr_overrun2", overrun, 0);
        err_clr = 1'b0;
        period_en = 1'b0;

        // Tick in cycle 129 with scheduling disabled must be ignored.
        step_to(130);
        chk("dis_no_start", pred_ap_start, 0);
        chk("dis_no_busy", busy, 0);
        chk("dis_no_overrun", overrun, 0);

        // ce_1 alternates 1/0 from cycle 130: ticks in cycles 148 and 168.
        period_en = 1'b1; ce_1 = 1'b1; ce_toggle = 1'b1;
        step_to(148); chk("ce_pre_tick", busy, 0);
        step_to(149); chk("ce_tick1", pred_ap_start, 1);
        pred_finish(64'h4);
        step();
        chk("ce_valid", yhat_valid, 1);
        chk("ce_yhat", yhat_out, 64'h4);
        pred_quiet();
        step_to(168); chk("ce_pre_tick2", busy, 0);
        step_to(169); chk("ce_tick2", pred_ap_start, 1);

        // Asynchronous reset in the middle of a RUN cycle.
        #3;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_start", pred_ap_start, 0);
        chk("arst_busy", busy, 0);
        chk("arst_valid", yhat_valid, 0);
        chk("arst_yhat", yhat_out, 0);
        chk("arst_q0", pred_xhat_q0, 0);
        chk("arst_q1", pred_xhat_q1, 0);
        chk("arst_uk", pred_uk, 0);
        ce_toggle = 1'b0; ce_1 = 1'b1;
        @(posedge clk_1); #1;
        ap_rst_n = 1'b1; cyc = 0;
        step_to(9);  chk("rel_pre_tick", pred_ap_start, 0);
        step_to(10); chk("rel_start", pred_ap_start, 1);
        chk("rel_uk", pred_uk, 64'hCC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
